rr_mux_arbiter: RTL

- Round-robin arbiter that shares a single `gen_mux`-selected resource (bus, memory port, register read port) among 2**N requesters.
- Produces a one-hot grant and a binary select that drives the `gen_mux` select input directly.
- Holds ownership until the resource signals completion, the owner withdraws, or a watchdog expires.
- Sits between the requesting masters and the shared datapath mux.

---
 rtl/arbiter_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/rr_mux_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: FSM state, release cause, counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    REL_DONE    = 2'd0,
    REL_DROP    = 2'd1,
    REL_TIMEOUT = 2'd2
  } rel_cause_t;

  // Watchdog counter width; at least one bit even when the watchdog is disabled.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner pick: first set request after i_last, wrapping, i_last itself lowest.
// Latency: purely combinational.
// Backpressure: none; ports i_req[M], i_last[N] -> o_any, o_winner[N].
module rr_priority_pick #(
  parameter int N = 2,
  parameter int M = 1 << N
) (
  input  logic [M-1:0] i_req,
  input  logic [N-1:0] i_last,
  output logic         o_any,
  output logic [N-1:0] o_winner
);

  logic [N-1:0]   w_shift;
  logic [2*M-2:0] w_dbl;
  logic [M-1:0]   w_rot;
  logic [N-1:0]   w_idx;

  // Rotation amount wraps naturally in N bits because M == 2**N.
  assign w_shift = i_last + N'(1);

  // Doubled vector so a variable part-select yields req rotated right by w_shift.
  assign w_dbl = {i_req[M-2:0], i_req};
  assign w_rot = w_dbl[w_shift +: M];

  // Fixed-priority encode: lowest set bit of the rotated vector wins.
  always_comb begin
    w_idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = N'(i);
    end
  end

  assign o_any    = |i_req;
  assign o_winner = w_idx + w_shift;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a gen_mux select; grant held until done, owner drop or watchdog.
// Latency: 1 cycle req->grant; every release passes one idle cycle before the next grant.
// Backpressure: requesters hold req level until served; non-owner requests wait for IDLE.
module rr_mux_arbiter
  import arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [(1<<N)-1:0] i_req,
  input  logic             i_done,
  output logic [(1<<N)-1:0] o_grant,
  output logic [N-1:0]     o_sel,
  output logic             o_busy,
  output logic             o_timeout
);

  localparam int M  = 1 << N;
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t   r_state, w_state_nxt;
  logic [M-1:0] r_grant, w_grant_nxt;
  logic [N-1:0] r_sel, w_sel_nxt;
  logic [N-1:0] r_last, w_last_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_count, w_count_nxt;

  logic         w_any;
  logic [N-1:0] w_winner;
  logic         w_release;
  rel_cause_t   w_cause;

  rr_priority_pick #(.N(N), .M(M)) u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Release evaluation in priority order; r_sel is the owner while in GRANT.
  always_comb begin
    w_release = 1'b1;
    w_cause   = REL_DONE;
    if (i_done) begin
      w_cause = REL_DONE;
    end else if (!i_req[r_sel]) begin
      w_cause = REL_DROP;
    end else if ((TIMEOUT != 0) && (r_count == LP_CNT_LAST)) begin
      w_cause = REL_TIMEOUT;
    end else begin
      w_release = 1'b0;
    end
  end

  // State register plus the registered outputs and bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_last    <= N'(M - 1);
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)     w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; sel is never touched on release.
  always_comb begin
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_count_nxt   = r_count;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = M'(1) << w_winner;
          w_sel_nxt   = w_winner;
          w_busy_nxt  = 1'b1;
          w_count_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_last_nxt    = r_sel;
          w_count_nxt   = '0;
          w_timeout_nxt = (w_cause == REL_TIMEOUT);
        end else if (TIMEOUT != 0) begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_grant   = r_grant;
  assign o_sel     = r_sel;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule
